trivium_stream: RTL and testbench

Parametrised Trivium stream-cipher controller. It accepts key, IV and data `DW` bits per cycle, performs a configurable warm-up, and XORs data with a `DW`-bit keystream word every accepted cycle. It generalises the bit-serial controller by adding:
- parallel datapath width,
- automatic key/IV word counting,
- a valid/ready input handshake,
- a registered output with valid and last flags,
- end-of-message key wipe.

It sits between the host serial/parallel interface and the output encoder.

---
 rtl/trivium_pkg.sv | 8 +
 rtl/trivium_core_w.sv | 44 ++++
 rtl/trivium_stream.sv | 103 ++++++++++
 tb/tb_trivium_stream.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// trivium_pkg: shared FSM states and sizing constants for the Trivium stream controller
package trivium_pkg;
    typedef enum logic [2:0] {IDLE, RECV, LOAD, WARMUP, READY} state_t;
    localparam int KEY_BITS = 80;
    localparam int IV_BITS = 80;
    localparam int STATE_BITS = 288;
    localparam int WARMUP_ROUNDS_DEF = 1152;
endpackage

// File: rtl/trivium_core_w.sv
// trivium_core_w: 288-bit Trivium state with a DW-way unrolled update; ks[0] is the earliest bit
module trivium_core_w
    import trivium_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr,
    input  logic                load,
    input  logic                en,
    input  logic [KEY_BITS-1:0] key,
    input  logic [IV_BITS-1:0]  iv,
    output logic [DW-1:0]       ks
);
    logic [STATE_BITS-1:0] st, sn;
    logic t1, t2, t3;

    // bit i holds s(i+1)
    always_comb begin
        sn = st;
        ks = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int i = 0; i < DW; i++) begin
            t1 = sn[65] ^ sn[92];
            t2 = sn[161] ^ sn[176];
            t3 = sn[242] ^ sn[287];
            ks[i] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (sn[90] & sn[91]) ^ sn[170];
            t2 = t2 ^ (sn[174] & sn[175]) ^ sn[263];
            t3 = t3 ^ (sn[285] & sn[286]) ^ sn[68];
            sn = {sn[286:177], t2, sn[175:93], t1, sn[91:0], t3};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) st <= '0;
        else if (clr) st <= '0;
        else if (load) st <= {3'b111, 112'b0, iv, 13'b0, key};
        else if (en) st <= sn;
    end
endmodule

// File: rtl/trivium_stream.sv
// trivium_stream: Trivium controller with key/IV loading, warm-up and valid/ready data XOR.
// Optional TRIVIUM_STREAM_CNT_EN adds a saturating ks_cnt_o count of READY words.
module trivium_stream
    import trivium_pkg::*;
#(
    parameter int DW = 8,
    parameter int WARMUP_ROUNDS = WARMUP_ROUNDS_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] dat_i,
    input  logic          vld_i,
    input  logic          last_i,
    input  logic          rekey_i,
    output logic          in_rdy_o,
    output logic [DW-1:0] dat_o,
    output logic          vld_o,
    output logic          last_o,
    output logic          ready_o,
    output logic          busy_o
`ifdef TRIVIUM_STREAM_CNT_EN
    ,
    output logic [31:0]   ks_cnt_o
`endif
);
    localparam int KW = 160 / DW;
    localparam int WC = WARMUP_ROUNDS / DW;
    localparam int CW = $clog2(WC + 1);

    state_t state, nxt;
    logic [7:0] wcnt;
    logic [CW-1:0] wu;
    logic [159:0] kiv;
    logic [DW-1:0] ks;
    logic acc, ok, lastw;

    assign in_rdy_o = state inside {IDLE, RECV, READY};
    assign ready_o = state == READY;
    assign busy_o = state inside {LOAD, WARMUP};
    assign acc = vld_i & in_rdy_o & ~rekey_i;
    assign ok = acc & ready_o;
    assign lastw = ok & last_i;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = acc ? RECV : IDLE;
            RECV:    nxt = (acc && wcnt == 8'(KW - 1)) ? LOAD : RECV;
            LOAD:    nxt = WARMUP;
            WARMUP:  nxt = (wu == CW'(WC - 1)) ? READY : WARMUP;
            READY:   nxt = lastw ? IDLE : READY;
            default: nxt = IDLE;
        endcase
        if (rekey_i) nxt = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt <= '0;
            wu <= '0;
            kiv <= '0;
            dat_o <= '0;
            vld_o <= 1'b0;
            last_o <= 1'b0;
        end else begin
            vld_o <= ok;
            last_o <= lastw;
            if (ok) dat_o <= dat_i ^ ks;
            if (rekey_i || lastw) begin
                wcnt <= '0;
                kiv <= '0;
            end else if (acc && !ready_o) begin
                kiv[int'(wcnt)*DW +: DW] <= dat_i;
                wcnt <= (wcnt == 8'(KW - 1)) ? 8'd0 : wcnt + 8'd1;
            end
            wu <= (state == WARMUP && !rekey_i && wu != CW'(WC - 1)) ? wu + 1'b1 : '0;
        end
    end

`ifdef TRIVIUM_STREAM_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ks_cnt_o <= '0;
        else if (state == RECV && nxt == LOAD) ks_cnt_o <= '0;
        else if (ok && ks_cnt_o != 32'hFFFF_FFFF) ks_cnt_o <= ks_cnt_o + 32'd1;
    end
`endif

    trivium_core_w #(.DW(DW)) u_core (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr(rekey_i | lastw),
        .load(state == LOAD),
        .en(state == WARMUP | ok),
        .key(kiv[79:0]),
        .iv(kiv[159:80]),
        .ks(ks)
    );
endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream: directed checks of trivium_stream (DW=8) against a bit-serial Trivium model
module tb_trivium_stream;
    localparam int DW = 8;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [7:0] e;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, vld = 1'b0, last = 1'b0, rekey = 1'b0;
    logic [DW-1:0] dat = '0;
    logic in_rdy, vld_o, last_o, ready_o, busy_o;
    logic [DW-1:0] dat_o;
    logic [255:0] ksm;
    int total = 0, bad = 0;
`ifdef TRIVIUM_STREAM_CNT_EN
    logic [31:0] ks_cnt;
`endif

    trivium_stream #(.DW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .dat_i(dat), .vld_i(vld), .last_i(last), .rekey_i(rekey),
        .in_rdy_o(in_rdy), .dat_o(dat_o), .vld_o(vld_o), .last_o(last_o),
        .ready_o(ready_o), .busy_o(busy_o)
`ifdef TRIVIUM_STREAM_CNT_EN
        , .ks_cnt_o(ks_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // reference: textbook bit-serial Trivium, s[1..288], 1152 blank rounds then 256 output bits
    task automatic gen(input logic [79:0] k, input logic [79:0] v);
        logic s[1:288];
        logic t1, t2, t3;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i] = k[i-1];
            s[93+i] = v[i-1];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < 1152 + 256; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            if (r >= 1152) ksm[r-1152] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i >= 179; i--) s[i] = s[i-1];
            s[178] = t2;
            for (int i = 177; i >= 95; i--) s[i] = s[i-1];
            s[94] = t1;
            for (int i = 93; i >= 2; i--) s[i] = s[i-1];
            s[1] = t3;
        end
    endtask

    task automatic load_kiv(input logic [79:0] k, input logic [79:0] v, input bit hold);
        logic [159:0] kv;
        kv = {v, k};
        for (int i = 0; i < 20; i++) begin
            dat = kv[i*8 +: 8];
            vld = 1'b1;
            tick;
        end
        dat = 8'hA5;
        vld = hold;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 400 && !ready_o; i++) begin
            if (busy_o) n++;
            tick;
        end
        vld = 1'b0;
        chk("ready_reached", 32'(ready_o), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input bit l, input int idx, input string nm);
        dat = d;
        last = l;
        vld = 1'b1;
        tick;
        vld = 1'b0;
        last = 1'b0;
        chk({nm, "_vld"}, 32'(vld_o), 32'd1);
        chk({nm, "_dat"}, 32'(dat_o), 32'(d ^ ksm[idx*8 +: 8]));
        chk({nm, "_last"}, 32'(last_o), 32'(l));
    endtask

    initial begin
        vec_t tab[16];
        int n, nv;
        logic [79:0] rk, rv;
        logic [31:0] r0, r1, r2;

        repeat (3) tick;
        chk("rst_dat", 32'(dat_o), 32'd0);
        chk("rst_vld", 32'(vld_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_inrdy", 32'(in_rdy), 32'd1);
`ifdef TRIVIUM_STREAM_CNT_EN
        chk("rst_cnt", ks_cnt, 32'd0);
`endif
        rst = 1'b0;
        tick;

        // zero key/IV, vld held high through LOAD/WARMUP
        gen(80'd0, 80'd0);
        for (int i = 0; i < 16; i++) begin
            tab[i].d = (i < 8) ? 8'h00 : 8'(i * 17 + 3);
            tab[i].l = (i == 15);
            tab[i].e = tab[i].d ^ ksm[i*8 +: 8];
        end
        load_kiv(80'd0, 80'd0, 1'b1);
        chk("load_inrdy", 32'(in_rdy), 32'd0);
        chk("load_busy", 32'(busy_o), 32'd1);
        wait_ready(n);
        chk("busy_cycles", 32'(n), 32'd145);
        chk("ready_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 16; i++) begin
            dat = tab[i].d;
            last = tab[i].l;
            vld = 1'b1;
            tick;
            chk("tab_vld", 32'(vld_o), 32'd1);
            chk("tab_dat", 32'(dat_o), 32'(tab[i].e));
            chk("tab_last", 32'(last_o), 32'(tab[i].l));
        end
        vld = 1'b0;
        last = 1'b0;
        chk("post_last_ready", 32'(ready_o), 32'd0);
        chk("post_last_inrdy", 32'(in_rdy), 32'd1);
`ifdef TRIVIUM_STREAM_CNT_EN
        chk("cnt16", ks_cnt, 32'd16);
`endif
        tick;
        chk("post_last_vld", 32'(vld_o), 32'd0);

        // gaps between data words must not disturb the keystream
        gen(80'h8000_0000_0000_0000_0000, 80'd0);
        load_kiv(80'h8000_0000_0000_0000_0000, 80'd0, 1'b0);
        wait_ready(n);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin
                tick;
                chk("gap_vld", 32'(vld_o), 32'd0);
            end
            send(8'(i * 29), i == 11, i, "gap");
            nv += int'(vld_o);
        end
        chk("gap_vld_count", 32'(nv), 32'd12);

        // rekey with a word presented drops it, reload restarts keystream
        r0 = $urandom; r1 = $urandom; r2 = $urandom;
        rk = {r0[15:0], r1, r2};
        r0 = $urandom; r1 = $urandom; r2 = $urandom;
        rv = {r0[15:0], r1, r2};
        gen(rk, rv);
        load_kiv(rk, rv, 1'b0);
        wait_ready(n);
        for (int i = 0; i < 3; i++) send(8'h5A, 1'b0, i, "rk");
        dat = 8'h33;
        vld = 1'b1;
        rekey = 1'b1;
        tick;
        vld = 1'b0;
        rekey = 1'b0;
        chk("rekey_vld", 32'(vld_o), 32'd0);
        chk("rekey_ready", 32'(ready_o), 32'd0);
        chk("rekey_inrdy", 32'(in_rdy), 32'd1);
        load_kiv(rk, rv, 1'b0);
        wait_ready(n);
        chk("rekey_busy_cycles", 32'(n), 32'd145);
        send(8'h00, 1'b0, 0, "reload0");
        send(8'hF0, 1'b0, 1, "reload1");
`ifdef TRIVIUM_STREAM_CNT_EN
        chk("cnt_reload", ks_cnt, 32'd2);
`endif

        // reset mid-warm-up
        rekey = 1'b1;
        tick;
        rekey = 1'b0;
        load_kiv(rk, rv, 1'b0);
        repeat (50) tick;
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        repeat (3) tick;
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_ready", 32'(ready_o), 32'd0);
        chk("mrst_inrdy", 32'(in_rdy), 32'd1);
        chk("mrst_vld", 32'(vld_o), 32'd0);
        rst = 1'b0;
        tick;
        chk("mrst_idle_busy", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
